// File: rtl/muldiv_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, FSM
// states, accumulate modes and the divide latency helper.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV_SETUP,
        ST_DIV_ITER,
        ST_DIV_FIX
    } state_e;

    // How the latched product combines with {hi,lo} when a multiply retires.
    typedef enum logic [1:0] {
        ACC_SET,
        ACC_ADD,
        ACC_SUB
    } acc_e;

    // One setup cycle, one cycle per quotient bit, one fix-up/write cycle.
    function automatic int div_lat(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/muldiv_iter_div.sv
// Radix-2 restoring divider. start_i captures the raw operands; the next
// cycle takes magnitudes and special-case flags, then WIDTH iterations
// produce one quotient bit each, MSB first. valid_o is high for one cycle
// while the sign-corrected quotient/remainder are presented.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic             setup_q, iter_q, valid_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic             qneg_q, rneg_q, dz_q, ovf_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, diff;
    logic             take;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    // Operand magnitudes for setup and one restoring step for iteration.
    always_comb begin
        a_neg  = sgn_q & a_q[WIDTH-1];
        b_neg  = sgn_q & b_q[WIDTH-1];
        a_abs  = a_neg ? (~a_q + 1'b1) : a_q;
        b_abs  = b_neg ? (~b_q + 1'b1) : b_q;
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        take   = ~diff[WIDTH];
        rem_nx = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], take};
    end

    // Sequencing: setup one cycle after start, then WIDTH iterations.
    always_ff @(posedge clk) begin
        if (reset) begin
            setup_q <= 1'b0;
            iter_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            setup_q <= start_i;
            valid_q <= iter_q && (cnt_q == '0);
            if (setup_q) begin
                iter_q <= 1'b1;
                cnt_q  <= CW'(WIDTH - 1);
            end else if (iter_q) begin
                if (cnt_q == '0) begin
                    iter_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    // Datapath: capture, setup (magnitudes, signs, flags), shift/subtract.
    always_ff @(posedge clk) begin
        if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            sgn_q <= signed_i;
        end
        if (setup_q) begin
            quo_q  <= a_abs;
            rem_q  <= '0;
            dvs_q  <= b_abs;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            dz_q   <= (b_q == '0);
            ovf_q  <= sgn_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        end else if (iter_q) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
        end
    end

    // Sign fix-up, with divide-by-zero and overflow overriding the result.
    always_comb begin
        quo_o = qneg_q ? (~quo_q + 1'b1) : quo_q;
        rem_o = rneg_q ? (~rem_q + 1'b1) : rem_q;
        if (dz_q) begin
            quo_o = '1;
            rem_o = a_q;
        end else if (ovf_q) begin
            quo_o = a_q;
            rem_o = '0;
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/muldiv_iter.sv
// E-stage multiply/divide unit owning HI/LO. Multiplies (incl. madd/msub)
// retire after MUL_LAT cycles; divides run on div_iter for WIDTH+2 cycles.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DIV_LAT = div_lat(WIDTH);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    acc_e               acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    logic               issue, mul_signed, div_start;
    logic [2*WIDTH-1:0] a_ext, b_ext, product, hilo_cur;
    logic               div_valid;
    logic [WIDTH-1:0]   div_quo, div_rem;

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start_i  (div_start),
        .signed_i (op == OP_DIV),
        .a_i      (a),
        .b_i      (b),
        .valid_o  (div_valid),
        .quo_o    (div_quo),
        .rem_o    (div_rem)
    );

    // Issue qualification and the full-width product of the issuing operands.
    always_comb begin
        issue      = start && !req && (state_q == ST_IDLE);
        mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        a_ext      = {{WIDTH{mul_signed & a[WIDTH-1]}}, a};
        b_ext      = {{WIDTH{mul_signed & b[WIDTH-1]}}, b};
        product    = a_ext * b_ext;
        hilo_cur   = {hi_q, lo_q};
    end

    // Next state, counter, and HI/LO writes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            state_d = ST_MUL;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                            prod_d  = product;
                            if (op == OP_MADD || op == OP_MADDU) begin
                                acc_d = ACC_ADD;
                            end else if (op == OP_MSUB || op == OP_MSUBU) begin
                                acc_d = ACC_SUB;
                            end else begin
                                acc_d = ACC_SET;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = ST_DIV_SETUP;
                            div_start = 1'b1;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    case (acc_q)
                        ACC_ADD: {hi_d, lo_d} = hilo_cur + prod_q;
                        ACC_SUB: {hi_d, lo_d} = hilo_cur - prod_q;
                        default: {hi_d, lo_d} = prod_q;
                    endcase
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV_SETUP: begin
                state_d = ST_DIV_ITER;
                cnt_d   = CNT_W'(WIDTH - 1);
            end
            ST_DIV_ITER: begin
                if (cnt_q == '0) begin
                    state_d = ST_DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV_FIX: begin
                if (div_valid) begin
                    lo_d    = div_quo;
                    hi_d    = div_rem;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural and control state; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Product and accumulate mode held for the multiply's duration.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        acc_q  <= acc_d;
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It owns the HI/LO architectural registers. Multiplies complete after a fixed configurable latency. Divides run on an iterative radix-2 restoring divider that produces one quotient bit per cycle. Beyond plain mult/div it adds multiply-accumulate (madd/msub), defined divide-by-zero and overflow results, a completion pulse, and exception-request gating of issue.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (even, ≥ 8).
- MUL_LAT, 5, busy cycles for every multiply-class op (≥ 1).
- Derived: DIV_LAT = WIDTH + 2 (1 setup, WIDTH iterations, 1 fix-up/write).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  issue qualifier for op; sampled each edge.
- op  in  4  operation code (muldiv_pkg).
- a  in  WIDTH  forwarded rs value.
- b  in  WIDTH  forwarded rt value.
- req  in  1  exception/interrupt request; flushes the instruction in E.
- busy  out  1  multi-cycle op in flight. Reset 0.
- done  out  1  one-cycle pulse on the cycle after HI/LO are written by a multi-cycle op. Reset 0.
- hi  out  WIDTH  HI register (mfhi reads it directly). Reset 0.
- lo  out  WIDTH  LO register. Reset 0.

## Operation
- Ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO. Other codes are no-ops.
- Issue occurs when start=1, req=0 and busy=0. Otherwise start is ignored, with no state change.
- MTHI/MTLO: write a into hi/lo at the issue edge. busy stays 0 and done stays 0.
- States: IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX.
  - IDLE → MUL on a multiply-class issue.
  - IDLE → DIV_SETUP on a DIV/DIVU issue.
- MUL:
  - At issue, latch the 2·WIDTH product (signed or unsigned per op).
  - Count down MUL_LAT cycles.
  - On the final edge:
    - plain mult: {hi,lo} ← product.
    - madd: {hi,lo} ← {hi,lo} + product.
    - msub: {hi,lo} ← {hi,lo} − product.
  - Accumulate arithmetic is modulo 2^(2·WIDTH).
  - Transition to IDLE.
- DIV_SETUP: latch operand absolute values (signed ops), result signs, and the zero/overflow flags.
- DIV_ITER: runs WIDTH cycles, one quotient bit per cycle, MSB first.
- DIV_FIX:
  - Apply signs: quotient negative iff signs differ; remainder takes the dividend sign.
  - Write lo ← quotient, hi ← remainder.
  - Transition to IDLE.
- Divide by zero (both signedness variants): lo ← all-ones, hi ← a. Full latency is still spent.
- Signed overflow (a = most-negative, b = −1): lo ← a, hi ← 0.
- HI/LO are never modified mid-operation.
- req during busy does not abort: the in-flight op belongs to an older, committed instruction.

## Timing
- Issue at edge T0: busy=1 from T0 to T0+L, where L = MUL_LAT or DIV_LAT. HI/LO update at edge T0+L, at which busy falls.
- done is high for the single cycle following edge T0+L.
- Back-to-back issue is allowed on the first cycle busy=0.
- Simultaneous start and req: req wins, nothing issues.
- reset mid-operation: at the next edge, busy=0, done=0, hi=lo=0, state=IDLE. Partial results are discarded.
- No combinational path from start/op/a/b to any output.

## Structure
- Package muldiv_pkg holds:
  - the op code localparams;
  - the state enum;
  - a function computing DIV_LAT from WIDTH.
- Sub-module div_iter holds the divider datapath (setup, iteration, sign fix-up, special cases) with a start/valid handshake.
- The multiply path, counter, HI/LO and the FSM live in the top.

## Test plan
- MULT a=0xFFFFFFFE, b=3 → busy for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy 34 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands → lo=0x7FFFFFFC, hi=1.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTLO 0xFFFFFFFF, MTHI 0, then MADDU a=1, b=1 → hi=1, lo=0. MSUB a=1, b=1 from hi=lo=0 → hi=lo=0xFFFFFFFF.
- start with req=1 (MULT and MTHI) → busy stays 0, hi/lo unchanged. start while busy → ignored, and the original result is unaffected.
- reset asserted in cycle 10 of a DIV → next cycle busy=0, done=0, hi=lo=0. A following MULT 6×7 → lo=42, hi=0.
